// File: rtl/note_scheduler.sv
// note_scheduler: walks the note chart ROM and releases each note LEAD_FRAMES ahead of its hit frame.
// Define NOTE_SCHED_HOLD_EN to pair hold-start/hold-end entries into one hold spawn and flag malformed charts.
module note_scheduler #(
    parameter int LEAD_FRAMES = 120,
    parameter int NUM_NOTES   = 145,
    parameter int TAIL_FRAMES = 180
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        abort,
    input  logic        pause,
    output logic [7:0]  rom_addr,
    input  logic [15:0] key_1,
    input  logic [15:0] key_2,
    input  logic [15:0] key_3,
    input  logic [15:0] key_4,
    output logic        spawn_valid,
    input  logic        spawn_ready,
    output logic [1:0]  spawn_type,
    output logic [13:0] spawn_hit,
    output logic [13:0] spawn_end,
    output logic [13:0] song_frame,
    output logic        busy,
    output logic        done,
    output logic        chart_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_PAUSED = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [14:0] LEAD_W = 15'(LEAD_FRAMES);
    localparam logic [8:0]  NUM_W  = 9'(NUM_NOTES);
    localparam logic [15:0] TAIL_W = 16'(TAIL_FRAMES);

    function automatic logic [13:0] sat_inc(input logic [13:0] value);
        logic [13:0] result;
        if (value == 14'h3FFF) begin
            result = value;
        end else begin
            result = value + 14'd1;
        end
        return result;
    endfunction

    state_t      state_r, state_s;
    logic [8:0]  ptr_r, ptr_s;
    logic [13:0] frame_r, frame_s;
    logic [15:0] tail_r, tail_s;
    logic        valid_r, valid_s;
    logic [1:0]  type_r, type_s;
    logic [13:0] hit_r, hit_s;
    logic [13:0] end_r, end_s;
    logic        err_r, err_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        eligible_s;
    logic        slot_free_s;
    logic        load_s;

    // The pointer is 9 bits so that it can sit at NUM_NOTES = 256 once the chart is exhausted.
    assign eligible_s  = (state_r == ST_RUN) && (ptr_r < NUM_W) &&
                         ({1'b0, key_1[13:0]} <= ({1'b0, frame_r} + LEAD_W));
    assign slot_free_s = !valid_r || spawn_ready;
    assign load_s      = eligible_s && slot_free_s;

`ifdef NOTE_SCHED_HOLD_EN
    logic hold_pair_s;
    logic unused_keys;
    assign hold_pair_s = (key_2[15:14] == 2'b10) && ((ptr_r + 9'd1) < NUM_W);
    assign unused_keys = ^{key_3, key_4};
`else
    logic unused_keys;
    assign unused_keys = ^{key_2, key_3, key_4};
`endif

    // Next-state and next-datapath values for the sequencer.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        frame_s = frame_r;
        tail_s  = tail_r;
        valid_s = valid_r;
        type_s  = type_r;
        hit_s   = hit_r;
        end_s   = end_r;
        err_s   = err_r;
        if (abort) begin
            state_s = ST_IDLE;
            valid_s = 1'b0;
        end else if (start) begin
            state_s = ST_RUN;
            ptr_s   = 9'd0;
            frame_s = 14'd0;
            tail_s  = 16'd0;
            valid_s = 1'b0;
            type_s  = 2'b00;
            hit_s   = 14'd0;
            end_s   = 14'd0;
            err_s   = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    frame_s = frame_tick ? sat_inc(frame_r) : frame_r;
                    valid_s = valid_r && !spawn_ready;
                    if (load_s) begin
                        ptr_s = ptr_r + 9'd1;
`ifdef NOTE_SCHED_HOLD_EN
                        case (key_1[15:14])
                            2'b00: begin
                                valid_s = 1'b1;
                                type_s  = 2'b00;
                                hit_s   = key_1[13:0];
                                end_s   = 14'd0;
                            end
                            2'b01: begin
                                valid_s = 1'b1;
                                hit_s   = key_1[13:0];
                                if (hold_pair_s) begin
                                    type_s = 2'b01;
                                    end_s  = key_2[13:0];
                                    ptr_s  = ptr_r + 9'd2;
                                end else begin
                                    type_s = 2'b00;
                                    end_s  = 14'd0;
                                    err_s  = 1'b1;
                                end
                            end
                            // Orphan hold end or reserved type: consumed without a spawn.
                            default: begin
                                err_s = 1'b1;
                            end
                        endcase
`else
                        valid_s = 1'b1;
                        type_s  = key_1[15:14];
                        hit_s   = key_1[13:0];
                        end_s   = 14'd0;
`endif
                    end else begin
                        ptr_s = ptr_r;
                    end
                    if (pause) begin
                        state_s = ST_PAUSED;
                    end else if (!load_s && (ptr_r >= NUM_W) && slot_free_s) begin
                        state_s = ST_DRAIN;
                        tail_s  = 16'd0;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_PAUSED: begin
                    valid_s = valid_r && !spawn_ready;
                    state_s = pause ? ST_PAUSED : ST_RUN;
                end
                ST_DRAIN: begin
                    valid_s = 1'b0;
                    frame_s = frame_tick ? sat_inc(frame_r) : frame_r;
                    if (TAIL_W == 16'd0) begin
                        state_s = ST_DONE;
                    end else if (frame_tick) begin
                        if ((tail_r + 16'd1) >= TAIL_W) begin
                            state_s = ST_DONE;
                        end else begin
                            tail_s = tail_r + 16'd1;
                        end
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    assign busy_s = (state_s == ST_RUN) || (state_s == ST_PAUSED) || (state_s == ST_DRAIN);
    assign done_s = (state_s == ST_DONE);

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= 9'd0;
            frame_r <= 14'd0;
            tail_r  <= 16'd0;
            valid_r <= 1'b0;
            type_r  <= 2'b00;
            hit_r   <= 14'd0;
            end_r   <= 14'd0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            frame_r <= frame_s;
            tail_r  <= tail_s;
            valid_r <= valid_s;
            type_r  <= type_s;
            hit_r   <= hit_s;
            end_r   <= end_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign rom_addr    = ptr_r[7:0];
    assign spawn_valid = valid_r;
    assign spawn_type  = type_r;
    assign spawn_hit   = hit_r;
    assign spawn_end   = end_r;
    assign song_frame  = frame_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign chart_err   = err_r;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: a 12-entry chart model, a spawn scoreboard, and checks on timing and state.
module tb_note_scheduler;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pause = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] key_1, key_2, key_3, key_4;
    logic        spawn_valid;
    logic        spawn_ready = 1'b0;
    logic [1:0]  spawn_type;
    logic [13:0] spawn_hit, spawn_end, song_frame;
    logic        busy, done, chart_err;

    logic [15:0] rom [0:255];
    logic [29:0] exp_q [$];
    int checks = 0;
    int errors = 0;

`ifdef NOTE_SCHED_HOLD_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    note_scheduler #(.LEAD_FRAMES(120), .NUM_NOTES(12), .TAIL_FRAMES(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start),
        .abort(abort), .pause(pause), .rom_addr(rom_addr),
        .key_1(key_1), .key_2(key_2), .key_3(key_3), .key_4(key_4),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_type(spawn_type),
        .spawn_hit(spawn_hit), .spawn_end(spawn_end), .song_frame(song_frame),
        .busy(busy), .done(done), .chart_err(chart_err)
    );

    always #5 Clk = ~Clk;

    assign key_1 = rom[rom_addr];
    assign key_2 = rom[8'(rom_addr + 8'd1)];
    assign key_3 = rom[8'(rom_addr + 8'd2)];
    assign key_4 = rom[8'(rom_addr + 8'd3)];

    // Scoreboard: every accepted spawn must match the next expected {type, hit, end}.
    always @(negedge Clk) begin
        if (Reset_n && spawn_valid && spawn_ready) begin
            logic [29:0] want;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 30'h3FFFFFFF;
            checks++;
            assert ({spawn_type, spawn_hit, spawn_end} === want) else begin
                errors++;
                $error("FAIL spawn observed=%0h expected=%0h", {spawn_type, spawn_hit, spawn_end}, want);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic check_zero();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_song_frame", 32'(song_frame), 32'd0);
        chk("rst_spawn", 32'({spawn_valid, spawn_type, spawn_hit, spawn_end}), 32'd0);
        chk("rst_flags", 32'({busy, done, chart_err}), 32'd0);
    endtask

    task automatic push_chart();
        exp_q.push_back({2'b00, 14'd50, 14'd0});
        exp_q.push_back({2'b00, 14'd240, 14'd0});
`ifdef NOTE_SCHED_HOLD_EN
        exp_q.push_back({2'b01, 14'd282, 14'd323});
`else
        exp_q.push_back({2'b01, 14'd282, 14'd0});
        exp_q.push_back({2'b10, 14'd323, 14'd0});
`endif
        exp_q.push_back({2'b00, 14'd400, 14'd0});
        exp_q.push_back({2'b00, 14'd401, 14'd0});
        exp_q.push_back({2'b00, 14'd402, 14'd0});
`ifdef NOTE_SCHED_HOLD_EN
        exp_q.push_back({2'b00, 14'd460, 14'd0});
`else
        exp_q.push_back({2'b10, 14'd450, 14'd0});
        exp_q.push_back({2'b01, 14'd460, 14'd0});
`endif
        exp_q.push_back({2'b00, 14'd470, 14'd0});
        exp_q.push_back({2'b00, 14'd600, 14'd0});
        exp_q.push_back({2'b00, 14'd610, 14'd0});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0]  = {2'b00, 14'd50};
        rom[1]  = {2'b00, 14'd240};
        rom[2]  = {2'b01, 14'd282};
        rom[3]  = {2'b10, 14'd323};
        rom[4]  = {2'b00, 14'd400};
        rom[5]  = {2'b00, 14'd401};
        rom[6]  = {2'b00, 14'd402};
        rom[7]  = {2'b10, 14'd450};
        rom[8]  = {2'b01, 14'd460};
        rom[9]  = {2'b00, 14'd470};
        rom[10] = {2'b00, 14'd600};
        rom[11] = {2'b00, 14'd610};

        #2 Reset_n = 1'b0;
        cyc(); cyc();
        check_zero();
        Reset_n = 1'b1;
        cyc();

        // First note: spawn two edges after start.
        push_chart();
        spawn_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_valid", 32'(spawn_valid), 32'd0);
        cyc();
        chk("first_valid", 32'(spawn_valid), 32'd1);
        chk("first_fields", 32'({spawn_type, spawn_hit}), 32'({2'b00, 14'd50}));
        chk("first_addr", 32'(rom_addr), 32'd1);
        cyc();
        chk("first_clear", 32'(spawn_valid), 32'd0);

        // Note at 240 waits for song_frame 120; the tick edge itself compares against 119.
        tick_n(119);
        chk("wait_addr", 32'(rom_addr), 32'd1);
        chk("wait_valid", 32'(spawn_valid), 32'd0);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("pre_inc_frame", 32'(song_frame), 32'd120);
        chk("pre_inc_valid", 32'(spawn_valid), 32'd0);
        cyc();
        chk("second_valid", 32'(spawn_valid), 32'd1);
        chk("second_hit", 32'(spawn_hit), 32'd240);
        chk("second_addr", 32'(rom_addr), 32'd2);

        // Hold pair (or two raw spawns) consumed by frame 210.
        tick_n(90);
        chk("hold_addr", 32'(rom_addr), 32'd4);

        // Back-pressure with three eligible notes.
        spawn_ready = 1'b0;
        tick_n(80);
        for (int i = 0; i < 5; i++) begin
            chk("stall_fields", 32'({spawn_valid, spawn_type, spawn_hit}), 32'({1'b1, 2'b00, 14'd400}));
            chk("stall_addr", 32'(rom_addr), 32'd5);
            cyc();
        end
        spawn_ready = 1'b1;
        cyc();
        chk("burst1", 32'({spawn_valid, spawn_hit, rom_addr}), 32'({1'b1, 14'd401, 8'd6}));
        cyc();
        chk("burst2", 32'({spawn_valid, spawn_hit, rom_addr}), 32'({1'b1, 14'd402, 8'd7}));
        cyc();
        chk("burst_end", 32'(spawn_valid), 32'd0);

        // Pause freezes song time.
        pause = 1'b1;
        cyc();
        tick_n(10);
        chk("pause_frame", 32'(song_frame), 32'd290);
        chk("pause_addr", 32'(rom_addr), 32'd7);
        chk("pause_busy", 32'(busy), 32'd1);
        pause = 1'b0;
        cyc();

        // Orphan hold end, then a hold start followed by a tap.
        tick_n(70);
        chk("orphan_addr", 32'(rom_addr), 32'd10);
        chk("orphan_err", 32'(chart_err), 32'(EXP_ERR));

        // Last two notes, then DRAIN.
        tick_n(130);
        cyc();
        chk("drain_flags", 32'({spawn_valid, busy, done}), 32'({1'b0, 1'b1, 1'b0}));
        chk("err_sticky", 32'(chart_err), 32'(EXP_ERR));
        tick_n(2);
        chk("drain_frame", 32'(song_frame), 32'd492);
        chk("drain_not_done", 32'(done), 32'd0);
        chk("queue_empty1", 32'(exp_q.size()), 32'd0);

        // Reset mid-DRAIN.
        Reset_n = 1'b0;
        #1;
        check_zero();
        cyc();
        Reset_n = 1'b1;
        cyc();

        // Second play: start coincides with frame_tick, full chart, DONE on the third tail tick.
        push_chart();
        start = 1'b1;
        frame_tick = 1'b1;
        cyc();
        start = 1'b0;
        frame_tick = 1'b0;
        chk("restart_frame", 32'(song_frame), 32'd0);
        chk("restart_err", 32'(chart_err), 32'd0);
        tick_n(490);
        cyc();
        chk("drain2_flags", 32'({busy, done}), 32'({1'b1, 1'b0}));
        tick_n(2);
        chk("tail2_not_done", 32'(done), 32'd0);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("tail3_done", 32'({busy, done}), 32'({1'b0, 1'b1}));
        chk("tail3_frame", 32'(song_frame), 32'd493);
        chk("queue_empty2", 32'(exp_q.size()), 32'd0);

        // abort beats start.
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_flags", 32'({busy, done, spawn_valid}), 32'd0);
        cyc();
        chk("abort_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
